// File: rtl/ad_regfile_wr_sched.sv
// ad_regfile_wr_sched
// Write-port scheduler for the single-write-port integer register file.
// After reset it sweeps every entry to zero, because the storage has no reset.
// It then shares the one write port among NUM_REQ writeback sources using
// round-robin arbitration. Writes to x0 complete their handshake but are not
// forwarded to the storage.
//
// Handshake: a requester raises req_valid_i[k] and holds its address, data
// and valid stable until it sees req_ready_o[k]. A transfer happens on the
// rising edge where both are high. Ready is computed combinationally from the
// valid bits and the round-robin pointer, and never from a requester's own
// earlier ready. The write appears on the registered rd_* outputs one cycle
// after the transfer edge.
module ad_regfile_wr_sched #(
  parameter int REG_DATA_WIDTH     = 32,
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int REGFILE_DEPTH      = 32,
  parameter int NUM_REQ            = 3
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [NUM_REQ-1:0]                     req_valid_i,
  output logic [NUM_REQ-1:0]                     req_ready_o,
  input  logic [NUM_REQ*REGFILE_ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ*REG_DATA_WIDTH-1:0]      req_data_i,
  output logic [REGFILE_ADDR_WIDTH-1:0]          rd_addr_o,
  output logic [REG_DATA_WIDTH-1:0]              rd_wr_data_o,
  output logic                                   rd_wr_en_o,
  output logic                                   init_done_o,
  output logic                                   dbg_state_o
);

  localparam int ADDR_W = REGFILE_ADDR_WIDTH;
  localparam int DATA_W = REG_DATA_WIDTH;
  localparam int PTR_W  = $clog2(NUM_REQ);

  localparam logic [ADDR_W-1:0] LAST_INIT_ADDR = ADDR_W'(REGFILE_DEPTH - 1);
  localparam logic [PTR_W-1:0]  PTR_RESET      = PTR_W'(NUM_REQ - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_en_q, rd_en_d;
  logic                init_done_q, init_done_d;

  // Unpacked views of the flattened requester buses.
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  // Arbitration results.
  logic                grant_found;
  logic [PTR_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0]  grant_vec;
  logic [PTR_W-1:0]    cand;

  // Split the flattened requester buses into per-requester slices.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      addr_arr[k] = req_addr_i[k*ADDR_W +: ADDR_W];
      data_arr[k] = req_data_i[k*DATA_W +: DATA_W];
    end
  end

  // Round-robin search: start just after the last winner and wrap around.
  // The first valid requester found wins. Grants are issued only in RUN.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_vec   = '0;
    cand        = '0;
    if (state_q == ST_RUN) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
        if (!grant_found && req_valid_i[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
      if (grant_found) begin
        grant_vec[grant_idx] = 1'b1;
      end
    end
  end

  // Next-state logic for the clear sweep and the write-port schedule.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    rd_en_d     = 1'b0;
    init_done_d = init_done_q;
    unique case (state_q)
      ST_INIT: begin
        // Clear one entry per cycle. x0 is included in the sweep.
        rd_en_d    = 1'b1;
        rd_addr_d  = init_cnt_q;
        rd_data_d  = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_INIT_ADDR) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        // A valid requester is always granted, so a set grant_found is a
        // transfer. With no transfer, address and data hold their values.
        if (grant_found) begin
          rd_addr_d = addr_arr[grant_idx];
          rd_data_d = data_arr[grant_idx];
          rd_en_d   = (addr_arr[grant_idx] != '0);
          rr_ptr_d  = grant_idx;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State and output registers. Reset drops any pending write and restarts
  // the sweep.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      rr_ptr_q    <= PTR_RESET;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      rd_en_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      rd_en_q     <= rd_en_d;
      init_done_q <= init_done_d;
    end
  end

  assign req_ready_o  = grant_vec;
  assign rd_addr_o    = rd_addr_q;
  assign rd_wr_data_o = rd_data_q;
  assign rd_wr_en_o   = rd_en_q;
  assign init_done_o  = init_done_q;
  assign dbg_state_o  = state_q;

endmodule
